// File: rtl/rob_commit_pkg.sv
// Shared ROB types: destination register type and per-entry record.
// Depth default used by rob_commit; the ROB_EXP_EN macro enables exceptions.
package rob_commit_pkg;

  localparam int RobDepth = 8;
  localparam int RegBits  = 5;

  typedef logic [RegBits-1:0] RegFile_t;

  typedef struct packed {
    logic     valid;
    logic     done;
    logic     exp;
    RegFile_t rd;
  } RobEntry_t;

endpackage

// File: rtl/rob_commit_ptr.sv
// Wrapping head/tail pointers and occupancy count for the ROB.
// DEPTH must be a power of two so pointer overflow wraps naturally.
module rob_ptr #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          inc_alloc_i,
  input  logic          inc_commit_i,
  input  logic          clear_i,
  output logic [AW-1:0] head_o,
  output logic [AW-1:0] tail_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (inc_commit_i) head_d = head_q + AW'(1);
    if (inc_alloc_i)  tail_d = tail_q + AW'(1);
    unique case ({inc_alloc_i, inc_commit_i})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_o  = head_q;
  assign tail_o  = tail_q;
  assign count_o = count_q;
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/rob_commit.sv
// Reorder buffer: allocate at decode, collect writebacks, retire in order.
// Define ROB_EXP_EN to store exception bits and flush on an excepting head.
module rob_commit
  import rob_commit_pkg::*;
#(
  parameter  int ROB_DEPTH = RobDepth,
  localparam int ROB       = $clog2(ROB_DEPTH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           dec_e_,
  input  logic           dec_invalid,
  input  RegFile_t       dec_rd,
  output logic [ROB-1:0] dec_rob_id,
  output logic           rob_full,
  input  logic           wb_e_,
  input  logic [ROB-1:0] wb_rob_id,
  input  logic           wb_exp,
  output logic           commit_e_,
  output logic [ROB-1:0] com_rob_id,
  output RegFile_t       com_rd,
  output logic           flush_,
  output logic [ROB-1:0] exp_rob_id
);

  logic [ROB_DEPTH-1:0] valid_q;
  logic [ROB_DEPTH-1:0] done_q;
  logic [ROB_DEPTH-1:0] exp_q;
  RegFile_t             rd_q [ROB_DEPTH];

  logic [ROB-1:0] head, tail;
  logic [ROB:0]   count;
  logic           full, empty;
  logic           alloc, commit, flush, wb_hit;
  RobEntry_t      head_e;

  rob_ptr #(.DEPTH(ROB_DEPTH)) u_ptr (
    .clk_i        (clk),
    .reset_i      (reset),
    .inc_alloc_i  (alloc),
    .inc_commit_i (commit),
    .clear_i      (flush),
    .head_o       (head),
    .tail_o       (tail),
    .count_o      (count),
    .full_o       (full),
    .empty_o      (empty)
  );

  assign head_e = '{valid: valid_q[head], done: done_q[head],
                    exp: exp_q[head], rd: rd_q[head]};

  assign wb_hit = !wb_e_ && valid_q[wb_rob_id];
  assign commit = !empty && head_e.valid && head_e.done && !head_e.exp;
  assign flush  = head_e.valid && head_e.done && head_e.exp;
  assign alloc  = !dec_e_ && !full && !flush;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      if (wb_hit) done_q[wb_rob_id] <= 1'b1;
      if (commit) valid_q[head] <= 1'b0;
      if (alloc) begin
        valid_q[tail] <= 1'b1;
        done_q[tail]  <= dec_invalid;
      end
    end
  end

`ifdef ROB_EXP_EN
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      exp_q <= '0;
    end else begin
      if (wb_hit) exp_q[wb_rob_id] <= wb_exp;
      if (alloc) exp_q[tail] <= 1'b0;
    end
  end
`else
  logic unused_wb_exp;
  assign unused_wb_exp = wb_exp;
  assign exp_q = '0;
`endif

  // Destination tag needs no reset: it is only read behind valid.
  always_ff @(posedge clk) begin
    if (alloc) rd_q[tail] <= dec_rd;
  end

  logic [ROB:0] unused_count;
  assign unused_count = count;

  assign dec_rob_id = tail;
  assign rob_full   = full;
  assign commit_e_  = !commit;
  assign com_rob_id = head;
  assign com_rd     = head_e.rd;
  assign flush_     = !flush;
  assign exp_rob_id = flush ? head : '0;

endmodule
